// File: rtl/osc_pkg.sv
// Shared types and helpers for the oscilloscope capture path.
// Covers FSM state encoding, slope selection and the trigger-crossing test.
package osc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        ARMED     = 3'd2,
        POST_FILL = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    // Sitting exactly on the level without crossing it is not an event.
    function automatic logic trig_event(input logic       slope,
                                        input logic [7:0] prev,
                                        input logic [7:0] cur,
                                        input logic [7:0] level);
        if (slope == SLOPE_RISE) begin
            return (prev < level) && (cur >= level);
        end
        return (prev > level) && (cur <= level);
    endfunction

endpackage

// File: rtl/osc_sample_ram.sv
// Simple dual-port sample memory: synchronous write, registered read.
// Only the read register is reset, so the array itself maps onto block RAM.
module osc_sample_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/osc_capture.sv
// ADC acquisition front end: sample clock generation, level/slope trigger with
// pre-trigger history, and a frozen circular record read back trigger-aligned.
module osc_capture
    import osc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int PRE     = 256,
    parameter int DIV     = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [7:0]        trig_level,
    input  logic              trig_slope,
    input  logic              auto_en,
    input  logic [7:0]        ad_data_in,
    output logic              ad_clk,
    output logic              busy,
    output logic              done,
    output logic              auto_trig,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int DIV_W = $clog2(DIV);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(DIV / 2);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(2**ADDR_W - PRE - 2);

    state_t             r_state;
    state_t             w_nextState;
    logic [DIV_W-1:0]   r_divCnt;
    logic [DIV_W-1:0]   w_divNext;
    logic               r_adClk;
    logic               w_tick;
    logic [7:0]         r_cur;
    logic [7:0]         r_prev;
    logic [ADDR_W-1:0]  r_wrPtr;
    logic [ADDR_W-1:0]  r_trigPtr;
    logic [ADDR_W-1:0]  r_preCnt;
    logic [ADDR_W-1:0]  r_postCnt;
    logic [TMO_W-1:0]   r_tmoCnt;
    logic               r_autoTrig;
    logic               w_busy;
    logic               w_we;
    logic               w_event;
    logic               w_start;
    logic               w_trigger;
    logic               w_forced;
    logic [ADDR_W-1:0]  w_rdPhys;

    assign w_divNext = (r_divCnt == DIV_LAST) ? '0 : r_divCnt + DIV_W'(1);
    assign w_tick    = (r_divCnt == DIV_LAST);
    assign w_busy    = (r_state == PRE_FILL) || (r_state == ARMED) || (r_state == POST_FILL);
    assign w_we      = w_tick && w_busy;
    assign w_event   = trig_event(trig_slope, r_prev, r_cur, trig_level);

    // ad_clk is registered from the next divider count so it stays low in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_divCnt <= '0;
            r_adClk  <= 1'b0;
            r_cur    <= '0;
            r_prev   <= '0;
        end else begin
            r_divCnt <= w_divNext;
            r_adClk  <= (w_divNext < DIV_HALF);
            if (w_tick) begin
                r_cur  <= ad_data_in;
                r_prev <= r_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_trigger   = 1'b0;
        w_forced    = 1'b0;
        if (abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (arm) begin
                        w_nextState = PRE_FILL;
                        w_start     = 1'b1;
                    end
                end
                PRE_FILL: begin
                    if (w_tick && (r_preCnt == PRE_LAST)) begin
                        w_nextState = ARMED;
                    end
                end
                ARMED: begin
                    if (w_tick) begin
                        if (w_event) begin
                            w_nextState = POST_FILL;
                            w_trigger   = 1'b1;
                        end else if (auto_en && (r_tmoCnt == TMO_MAX)) begin
                            w_nextState = POST_FILL;
                            w_trigger   = 1'b1;
                            w_forced    = 1'b1;
                        end
                    end
                end
                POST_FILL: begin
                    if (w_tick && (r_postCnt == POST_LAST)) begin
                        w_nextState = DONE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // The trigger pointer marks the sample written on the triggering tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_trigPtr  <= '0;
            r_preCnt   <= '0;
            r_postCnt  <= '0;
            r_tmoCnt   <= '0;
            r_autoTrig <= 1'b0;
        end else begin
            if (w_start) begin
                r_wrPtr <= '0;
            end else if (w_we) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end

            if (w_start) begin
                r_preCnt <= '0;
            end else if (w_tick && (r_state == PRE_FILL)) begin
                r_preCnt <= r_preCnt + ADDR_W'(1);
            end

            if (r_state != ARMED) begin
                r_tmoCnt <= '0;
            end else if (w_tick && (r_tmoCnt != TMO_MAX)) begin
                r_tmoCnt <= r_tmoCnt + TMO_W'(1);
            end

            if (r_state != POST_FILL) begin
                r_postCnt <= '0;
            end else if (w_tick) begin
                r_postCnt <= r_postCnt + ADDR_W'(1);
            end

            if (w_trigger) begin
                r_trigPtr <= r_wrPtr;
            end

            if (w_start) begin
                r_autoTrig <= 1'b0;
            end else if (w_forced) begin
                r_autoTrig <= 1'b1;
            end
        end
    end

    assign w_rdPhys = r_trigPtr - PRE_OFS + rd_addr;

    osc_sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we),
        .i_wrAddr (r_wrPtr),
        .i_wrData (r_cur),
        .i_rdAddr (w_rdPhys),
        .o_rdData (rd_data)
    );

    assign ad_clk    = r_adClk;
    assign busy      = w_busy;
    assign done      = (r_state == DONE);
    assign auto_trig = r_autoTrig;

endmodule

// File: tb/tb_osc_capture.sv
// Scenario bench for osc_capture: streams ADC patterns one value per sample
// tick, then reads the frozen record back against queued expectations.
module tb_osc_capture;
   import osc_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int PRE     = 256;
   localparam int DIV     = 4;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              arm;
   logic              abort;
   logic [7:0]        trig_level;
   logic              trig_slope;
   logic              auto_en;
   logic [7:0]        ad_data_in;
   logic              ad_clk;
   logic              busy;
   logic              done;
   logic              auto_trig;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;

   int vecCount  = 0;
   int missCount = 0;

   int         addrQ[$];
   logic [7:0] expQ[$];

   always #10 clk = ~clk;

   osc_capture #(
      .ADDR_W  (ADDR_W),
      .PRE     (PRE),
      .DIV     (DIV),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .arm        (arm),
      .abort      (abort),
      .trig_level (trig_level),
      .trig_slope (trig_slope),
      .auto_en    (auto_en),
      .ad_data_in (ad_data_in),
      .ad_clk     (ad_clk),
      .busy       (busy),
      .done       (done),
      .auto_trig  (auto_trig),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   // Hang guard: the whole run is far shorter than this.
   initial begin
      #(20 * 80000);
      $display("[TB] FAIL watchdog: still running at %0t, required $finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Stimulus value for stream index n of each pattern.
   function automatic logic [7:0] sampleFor(input int mode, input int n);
      case (mode)
         0: return (n < 300) ? 8'd0 : 8'((n - 300) & 255);
         1: return (((n / 4) % 2) == 0) ? 8'd200 : 8'd50;
         2: return 8'd10;
         default: return (n <= 200) ? 8'(n) : 8'd200;
      endcase
   endfunction

   // Arms at a tick boundary, then presents one new value per ADC sample.
   // nDone is the tick index on which done rose, or -1 if it never did.
   task automatic runStream(input int mode, input int maxN, input int armA,
                            input int armB, output int nDone);
      nDone = -1;
      @(posedge ad_clk); #1;
      ad_data_in = sampleFor(mode, 0);
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      for (int n = 1; n <= maxN; n++) begin
         @(posedge ad_clk); #1;
         if (done) begin
            nDone = n;
            break;
         end
         ad_data_in = sampleFor(mode, n);
         if (n == armA || n == armB) begin
            arm = 1'b1;
            @(posedge clk); #1;
            arm = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      logic expAd;
      reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_level = 8'd128;
      trig_slope = SLOPE_RISE; auto_en = 1'b0; ad_data_in = 8'd0; rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      vecCount++;
      if ({ad_clk, busy, done, auto_trig} !== 4'b0000) begin
         missCount++;
         $display("[TB] FAIL reset_flags: got ad_clk/busy/done/auto=%b, expected 0000",
                  {ad_clk, busy, done, auto_trig});
      end
      vecCount++;
      if (rd_data !== 8'd0) begin
         missCount++;
         $display("[TB] FAIL reset_rd_data: got %0d, expected 0", rd_data);
      end
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         expAd = ((k % DIV) < (DIV / 2));
         vecCount++;
         if (ad_clk !== expAd || busy !== 1'b0 || done !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL idle_cycle_%0d: got ad_clk=%b busy=%b done=%b, expected ad_clk=%b busy=0 done=0",
                     k, ad_clk, busy, done, expAd);
         end
      end
   endtask

   task automatic test_ramp_rising;
      int n;
      int a;
      logic [7:0] e;
      trig_level = 8'd128; trig_slope = SLOPE_RISE; auto_en = 1'b0;
      addrQ.push_back(256);  expQ.push_back(8'd128);
      addrQ.push_back(255);  expQ.push_back(8'd127);
      addrQ.push_back(0);    expQ.push_back(8'd0);
      addrQ.push_back(128);  expQ.push_back(8'd0);
      addrQ.push_back(200);  expQ.push_back(8'd72);
      addrQ.push_back(1023); expQ.push_back(8'd127);
      runStream(0, 1400, 350, 600, n);
      vecCount++;
      if (n < 0 || done !== 1'b1 || busy !== 1'b0 || auto_trig !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL ramp_done: got tick=%0d done=%b busy=%b auto=%b, expected done=1 busy=0 auto=0",
                  n, done, busy, auto_trig);
      end
      while (addrQ.size() > 0) begin
         a = addrQ.pop_front();
         e = expQ.pop_front();
         rd_addr = ADDR_W'(a);
         @(posedge clk); #1;
         vecCount++;
         if (rd_data !== e) begin
            missCount++;
            $display("[TB] FAIL ramp_read rd_addr=%0d: got %0d, expected %0d", a, rd_data, e);
         end
      end
   endtask

   task automatic test_falling_square;
      int n;
      int a;
      logic [7:0] e;
      trig_level = 8'd100; trig_slope = SLOPE_FALL; auto_en = 1'b0;
      addrQ.push_back(PRE);     expQ.push_back(8'd50);
      addrQ.push_back(PRE - 1); expQ.push_back(8'd200);
      addrQ.push_back(252);     expQ.push_back(8'd200);
      addrQ.push_back(251);     expQ.push_back(8'd50);
      addrQ.push_back(259);     expQ.push_back(8'd50);
      addrQ.push_back(260);     expQ.push_back(8'd200);
      runStream(1, 1400, -1, -1, n);
      vecCount++;
      if (n < 0 || done !== 1'b1 || auto_trig !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL square_done: got tick=%0d done=%b auto=%b, expected done=1 auto=0",
                  n, done, auto_trig);
      end
      while (addrQ.size() > 0) begin
         a = addrQ.pop_front();
         e = expQ.pop_front();
         rd_addr = ADDR_W'(a);
         @(posedge clk); #1;
         vecCount++;
         if (rd_data !== e) begin
            missCount++;
            $display("[TB] FAIL square_read rd_addr=%0d: got %0d, expected %0d", a, rd_data, e);
         end
      end
   endtask

   task automatic test_auto_timeout;
      int n;
      int a;
      logic [7:0] e;
      trig_level = 8'd128; trig_slope = SLOPE_RISE; auto_en = 1'b1;
      addrQ.push_back(256);  expQ.push_back(8'd10);
      addrQ.push_back(0);    expQ.push_back(8'd10);
      addrQ.push_back(1023); expQ.push_back(8'd10);
      runStream(2, 1400, -1, -1, n);
      // PRE fill ticks, TIMEOUT+1 armed ticks, then the post-trigger samples.
      vecCount++;
      if (n !== PRE + TIMEOUT + 1 + (2**ADDR_W - PRE - 1)) begin
         missCount++;
         $display("[TB] FAIL auto_latency: got done on tick %0d, expected tick %0d",
                  n, PRE + TIMEOUT + 1 + (2**ADDR_W - PRE - 1));
      end
      vecCount++;
      if (auto_trig !== 1'b1 || busy !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL auto_flag: got auto=%b busy=%b, expected auto=1 busy=0", auto_trig, busy);
      end
      while (addrQ.size() > 0) begin
         a = addrQ.pop_front();
         e = expQ.pop_front();
         rd_addr = ADDR_W'(a);
         @(posedge clk); #1;
         vecCount++;
         if (rd_data !== e) begin
            missCount++;
            $display("[TB] FAIL auto_read rd_addr=%0d: got %0d, expected %0d", a, rd_data, e);
         end
      end
      auto_en = 1'b0;
      runStream(2, 1200, -1, -1, n);
      vecCount++;
      if (n !== -1 || busy !== 1'b1 || done !== 1'b0 || auto_trig !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL no_auto_stays_armed: got tick=%0d busy=%b done=%b auto=%b, expected -1/1/0/0",
                  n, busy, done, auto_trig);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      vecCount++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL abort_idle: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_prefill_cross;
      int n;
      trig_level = 8'd128; trig_slope = SLOPE_RISE; auto_en = 1'b0;
      runStream(3, 1200, -1, -1, n);
      vecCount++;
      if (n !== -1 || busy !== 1'b1 || done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL prefill_cross_ignored: got tick=%0d busy=%b done=%b, expected -1/1/0",
                  n, busy, done);
      end
      abort = 1'b1;
      arm   = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      arm   = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      vecCount++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL abort_beats_arm: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_reset_post_fill;
      int n;
      int a;
      logic [7:0] e;
      trig_level = 8'd128; trig_slope = SLOPE_RISE; auto_en = 1'b0;
      rd_addr = ADDR_W'(256);
      runStream(0, 700, -1, -1, n);
      vecCount++;
      if (n !== -1 || busy !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL post_fill_reached: got tick=%0d busy=%b, expected -1 busy=1", n, busy);
      end
      reset = 1'b1;
      #2;
      vecCount++;
      if ({ad_clk, busy, done, auto_trig} !== 4'b0000 || rd_data !== 8'd0) begin
         missCount++;
         $display("[TB] FAIL async_reset: got ad_clk/busy/done/auto=%b rd_data=%0d, expected 0000 and 0",
                  {ad_clk, busy, done, auto_trig}, rd_data);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      addrQ.push_back(256); expQ.push_back(8'd128);
      addrQ.push_back(255); expQ.push_back(8'd127);
      addrQ.push_back(0);   expQ.push_back(8'd0);
      runStream(0, 1400, -1, -1, n);
      vecCount++;
      if (n < 0 || done !== 1'b1 || auto_trig !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL recapture_done: got tick=%0d done=%b auto=%b, expected done=1 auto=0",
                  n, done, auto_trig);
      end
      while (addrQ.size() > 0) begin
         a = addrQ.pop_front();
         e = expQ.pop_front();
         rd_addr = ADDR_W'(a);
         @(posedge clk); #1;
         vecCount++;
         if (rd_data !== e) begin
            missCount++;
            $display("[TB] FAIL recapture_read rd_addr=%0d: got %0d, expected %0d", a, rd_data, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_rising();
      test_falling_square();
      test_auto_timeout();
      test_prefill_cross();
      test_reset_post_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/osc_capture.md
Name: osc_capture

Overview:
- Upstream acquisition stage of the oscilloscope (OSI) path.
- Generates the ADC sample clock and samples the 8-bit ADC bus.
- Applies a level/slope trigger with pre-trigger history and freezes one record in a circular sample RAM.
- The HDMI waveform renderer reads the record back through a trigger-aligned read port. Arming comes from the OSI confirm/quit controls.

Parameters:
- ADDR_W, 10, record depth is 2**ADDR_W samples (1024).
- PRE, 256, samples kept before the trigger point; must be < 2**ADDR_W.
- DIV, 4, clk cycles per ADC sample; must be an even number ≥ 2.
- TIMEOUT, 65535, samples after arming before auto mode forces a trigger.

Ports:
- clk  in  1  system clock (50 MHz domain)
- reset  in  1  asynchronous, active-high
- arm  in  1  single-cycle pulse; start a capture
- abort  in  1  single-cycle pulse; cancel the capture and return to IDLE
- trig_level  in  8  trigger threshold, unsigned
- trig_slope  in  1  0 = rising edge, 1 = falling edge
- auto_en  in  1  1 = force a trigger after TIMEOUT
- ad_data_in  in  8  ADC sample bus, unsigned
- ad_clk  out  1  ADC sample clock
- busy  out  1  high while a capture is in progress
- done  out  1  high while a frozen record is available
- auto_trig  out  1  last record was forced by timeout
- rd_addr  in  ADDR_W  sample index relative to record start; index PRE is the trigger sample
- rd_data  out  8  sample at rd_addr

Behaviour:
- Reset values: ad_clk = 0, busy = 0, done = 0, auto_trig = 0, rd_data = 0, state = IDLE, all pointers and counters 0. Reset mid-capture discards the record immediately.
- Sample tick:
  - Free-running divider counts 0..DIV-1.
  - ad_clk = 1 for count < DIV/2, else 0.
  - tick = 1 when count == DIV-1; ad_data_in is registered into cur on that cycle, and the old cur moves to prev.
  - Divider runs in every state.
- Write: in PRE_FILL, ARMED and POST_FILL, every tick writes cur to RAM at wr_ptr, then wr_ptr increments modulo 2**ADDR_W (wrap is silent).
- Trigger event, evaluated on ticks in ARMED only:
  - rising: prev < trig_level and cur >= trig_level
  - falling: prev > trig_level and cur <= trig_level
  - Equal-to-level with no crossing is not an event.
- States:
  - IDLE: busy = 0. arm → PRE_FILL with wr_ptr = 0, pre_cnt = 0, done = 0, auto_trig = 0.
  - PRE_FILL: count written samples. When pre_cnt reaches PRE → ARMED, tmo_cnt = 0. Trigger events are ignored here.
  - ARMED: on an event, trig_ptr = address of the sample just written (wr_ptr before increment) → POST_FILL, post_cnt = 0. Otherwise, when auto_en = 1 and tmo_cnt == TIMEOUT → the same action with auto_trig = 1. tmo_cnt increments per tick and saturates.
  - POST_FILL: when post_cnt reaches 2**ADDR_W - PRE - 1 further samples → DONE.
  - DONE: done = 1, busy = 0, no writes. arm → PRE_FILL (a new capture starts and done drops the next cycle).
- busy = 1 in PRE_FILL, ARMED and POST_FILL.
- arm while busy is ignored. abort in any state → IDLE and done = 0. If abort and arm arrive in the same cycle, abort wins.
- Read port:
  - Physical address = (trig_ptr - PRE + rd_addr) mod 2**ADDR_W.
  - rd_data is registered with 1-cycle latency and is valid only while done = 1.
  - A read and a write in the same cycle never target the same record, because writes stop in DONE.

Decomposition:
- osc_pkg holds:
  - state encoding IDLE, PRE_FILL, ARMED, POST_FILL, DONE (3-bit)
  - slope constants SLOPE_RISE = 0, SLOPE_FALL = 1
- Sub-module osc_sample_ram: simple dual-port, 8 x 2**ADDR_W, synchronous write, registered read, maps to block RAM. It has no reset on the array.

Test Plan:
- Reset, then idle 20 cycles → ad_clk toggles with period DIV (4 clk at default), busy = 0, done = 0.
- trig_level = 128, rising slope, ramp input 0..255 stepping +1 per tick, arm → done asserts; rd_addr = 256 gives 128, rd_addr = 255 gives 127, rd_addr = 0 gives 0 (pre-fill window), auto_trig = 0.
- Falling slope, trig_level = 100, square wave 200/50 → trigger sample reads ≤ 100 and rd_addr = PRE-1 reads 200.
- Constant input 10, auto_en = 1, TIMEOUT = 16 (test override) → done with auto_trig = 1; with auto_en = 0 the block stays in ARMED indefinitely.
- Crossing during PRE_FILL only, then a flat input → no trigger; arm pulses while busy have no effect; abort + arm in the same cycle → IDLE.
- Assert reset during POST_FILL → all outputs return to reset values asynchronously; a subsequent arm completes a normal capture.
